mem_access_stage: RTL

- MEM-stage consumer of the EXE stage output in the 16-bit pipeline.
- Takes the latched ALU result, store operand and control bits from the EXE/MEM register.
- Drives a req/ack data-memory bus; the memory may insert wait states.
- Stalls the upstream pipeline until the access completes, then presents one write-back record (ALU result or load data) to the WB stage.

---
 rtl/mem_access_stage_pkg.sv | 18 +
 rtl/mem_timeout_counter.sv | 31 +++
 rtl/mem_access_stage.sv | 123 ++++++++++++
 3 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared constants for the MEM stage: FSM encoding, default widths, abort write-back value.
// Build option: MEM_TIMEOUT_EN adds the bus timeout default.
package mem_access_stage_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam int RD_W_DEF   = 3;
`ifdef MEM_TIMEOUT_EN
    localparam int TIMEOUT_CYC_DEF = 15;
`endif

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    // wb_data value for aborted accesses, also used as the reset value
    localparam int ABORT_WB_DATA = 0;

endpackage

// File: rtl/mem_timeout_counter.sv
// BUSY-cycle counter; expire is high during the LIMIT-th counted cycle. Exists only with MEM_TIMEOUT_EN.
// Latency: expire is combinational from the count. Backpressure: none, count_en simply gates counting.
// clear has priority over count_en so a fresh access always starts from zero.
`ifdef MEM_TIMEOUT_EN
module mem_timeout_counter #(
    parameter int LIMIT = 15,
    localparam int CW   = $clog2(LIMIT + 1)
)(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count_en,
    output logic expire
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count_en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = count_en && (cnt == CW'(LIMIT - 1));

endmodule
`endif

// File: rtl/mem_access_stage.sv
// MEM stage: issues one req/ack data-memory access per instruction and emits a write-back record.
// Latency: 1 cycle for ALU ops, 2 + wait states for loads/stores. Optional MEM_TIMEOUT_EN aborts hung accesses.
// Backpressure: stall holds upstream from acceptance until the ack (or abort) cycle; one access in flight.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int RD_W   = RD_W_DEF
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
`endif
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [DATA_W-1:0] store_data,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic              reg_write,
    input  logic [RD_W-1:0]   rd,
    output logic              stall,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    output logic [DATA_W-1:0] wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic              wb_reg_write,
    output logic              mem_err
);

    logic [0:0]        state;
    logic [DATA_W-1:0] alu_q;
    logic [RD_W-1:0]   rd_q;
    logic              rw_q;
    logic              mem_op;
    logic              accept;
    logic              expire;

    assign mem_op  = mem_read | mem_write;
    assign accept  = (state == ST_IDLE) && in_valid && mem_op;
    assign mem_req = (state == ST_BUSY);

`ifdef MEM_TIMEOUT_EN
    logic cnt_expire;

    mem_timeout_counter #(.LIMIT(TIMEOUT_CYC)) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (accept),
        .count_en (mem_req),
        .expire   (cnt_expire)
    );

    // an ack on the limit cycle wins over the abort
    assign expire = cnt_expire & ~mem_ack;
`else
    assign expire = 1'b0;
`endif

    // on abort upstream is released too, so the dropped instruction is not re-issued
    assign stall = accept | (mem_req & ~mem_ack & ~expire);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            alu_q        <= '0;
            rd_q         <= '0;
            rw_q         <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            out_valid    <= 1'b0;
            wb_data      <= DATA_W'(ABORT_WB_DATA);
            wb_rd        <= '0;
            wb_reg_write <= 1'b0;
            mem_err      <= 1'b0;
        end else begin
            out_valid    <= 1'b0;
            wb_reg_write <= 1'b0;
            mem_err      <= 1'b0;
            if (state == ST_IDLE) begin
                if (in_valid) begin
                    alu_q <= alu_result;
                    rd_q  <= rd;
                    rw_q  <= reg_write;
                    if (mem_op) begin
                        mem_addr  <= alu_result[ADDR_W-1:0];
                        mem_wdata <= store_data;
                        mem_we    <= mem_write;
                        state     <= ST_BUSY;
                    end else begin
                        out_valid    <= 1'b1;
                        wb_data      <= alu_result;
                        wb_rd        <= rd;
                        wb_reg_write <= reg_write;
                    end
                end
            end else begin
                if (mem_ack) begin
                    state        <= ST_IDLE;
                    out_valid    <= 1'b1;
                    wb_data      <= mem_we ? alu_q : mem_rdata;
                    wb_rd        <= rd_q;
                    wb_reg_write <= rw_q & ~mem_we;
                end else if (expire) begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b1;
                    mem_err   <= 1'b1;
                    wb_data   <= DATA_W'(ABORT_WB_DATA);
                    wb_rd     <= rd_q;
                end
            end
        end
    end

endmodule
